// File: rtl/freq_meter_pkg.sv
// Purpose: shared state encoding and default gate length for the frequency meter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package freq_meter_pkg;

  // Measurement controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_t;

  // 1 s gate window at a 50 MHz clkin.
  localparam int unsigned DEFAULT_GATE_CYCLES = 50_000_000;

endpackage

// File: rtl/edge_sync.sv
// Purpose: two-flop synchroniser for an asynchronous input plus a rising-edge detector.
// Latency: a din rise is reported on rise 3 clkin edges after it is first sampled.
// Backpressure: none; free-running.
// Ports: clkin (clock), rst (sync active-high reset), din (async input),
//        rise (one-cycle pulse per synchronised rising edge of din).
module edge_sync (
  input  logic clkin,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge clkin) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // sync3 is only a delayed copy of sync2 for edge detection.
  assign rise = sync2 & ~sync3;

endmodule

// File: rtl/freq_meter.sv
// Purpose: counts sigin rising edges over a GATE_CYCLES window and measures the sigin period.
// Latency: freq/ovf/valid update on the edge after the last gate cycle; sigin edges lag 3 cycles.
// Backpressure: none; results are overwritten each window, valid is a one-cycle strobe.
// Ports: clkin, rst (sync active-high), en (level enable), sigin (async measured signal),
//        freq (edges in last window), period (clkin cycles between last two rises),
//        valid (pulse with each freq/ovf update), ovf (last window saturated), busy (in GATE).
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEFAULT_GATE_CYCLES,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             sigin,
  output logic [CNT_W-1:0] freq,
  output logic [31:0]      period,
  output logic             valid,
  output logic             ovf,
  output logic             busy
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic               start_win;
  logic               latch_now;
  logic               rise;
  logic [GATE_W-1:0]  gate_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic               win_ovf;
  logic [31:0]        run_cnt;
  logic               seen_edge;

  edge_sync u_edge_sync (
    .clkin (clkin),
    .rst   (rst),
    .din   (sigin),
    .rise  (rise)
  );

  // Next-state logic. start_win marks every entry into GATE so the window
  // counters are cleared on the same edge the gate opens.
  always_comb begin
    state_nxt = state;
    start_win = 1'b0;
    latch_now = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = GATE;
          start_win = 1'b1;
        end
      end
      GATE: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (gate_cnt == GATE_LAST) begin
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        latch_now = 1'b1;
        if (en) begin
          state_nxt = GATE;
          start_win = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window counters and result registers. valid is registered so that it is
  // high in the same cycle the new freq/ovf values are visible.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      win_ovf  <= 1'b0;
      freq     <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
    end else begin
      state <= state_nxt;
      valid <= latch_now;
      if (start_win) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        win_ovf  <= 1'b0;
      end else if (state == GATE) begin
        gate_cnt <= gate_cnt + 1'b1;
        if (rise) begin
          // A rise arriving with the counter already full is an overflow.
          if (edge_cnt == '1) begin
            win_ovf <= 1'b1;
          end else begin
            edge_cnt <= edge_cnt + 1'b1;
          end
        end
      end
      if (latch_now) begin
        freq <= edge_cnt;
        ovf  <= win_ovf;
      end
    end
  end

  // Period measurement runs independently of the gate window. run_cnt restarts
  // at 1 on a rise so that rises N cycles apart report period = N.
  always_ff @(posedge clkin) begin
    if (rst) begin
      run_cnt   <= '0;
      seen_edge <= 1'b0;
      period    <= '0;
    end else if (!en) begin
      run_cnt   <= '0;
      seen_edge <= 1'b0;
    end else if (rise) begin
      if (seen_edge) begin
        period <= run_cnt;
      end
      run_cnt   <= 32'd1;
      seen_edge <= 1'b1;
    end else if (run_cnt != '1) begin
      run_cnt <= run_cnt + 32'd1;
    end
  end

  assign busy = (state == GATE);

endmodule

// File: tb/tb_freq_meter.sv
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int G = 100;       // gate cycles
  localparam int W = G + 1;     // window repeat interval
  localparam int HMAX = 8192;

  logic clkin = 1'b0;
  always #5 clkin = ~clkin;

  logic        rst, en, sigin;
  logic [31:0] freq;
  logic [31:0] period;
  logic        valid, ovf, busy;

  logic        en4, sigin4;
  logic [3:0]  freq4;
  logic [31:0] period4;
  logic        valid4, ovf4, busy4;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(32)) dut (
    .clkin(clkin), .rst(rst), .en(en), .sigin(sigin),
    .freq(freq), .period(period), .valid(valid), .ovf(ovf), .busy(busy)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
    .clkin(clkin), .rst(rst), .en(en4), .sigin(sigin4),
    .freq(freq4), .period(period4), .valid(valid4), .ovf(ovf4), .busy(busy4)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic s_hist [0:HMAX-1];   // sigin as sampled on each clkin edge

  typedef struct {
    int hp;          // sigin half-period in cycles, 0 = held low
    int exp_freq;
    int exp_period;
    int exp_ovf;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // One clkin edge; outputs are read 1 ns later, inputs changed from then on.
  task automatic tick();
    @(posedge clkin);
    cyc++;
    if (cyc < HMAX) s_hist[cyc] = sigin;
    #1;
  endtask

  task automatic reset_all();
    rst = 1'b1; en = 1'b0; en4 = 1'b0; sigin = 1'b0; sigin4 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  // Ticks until dut.valid, counting edges including the first; n=-1 on timeout.
  task automatic wait_valid(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (valid) begin
        n = i;
        break;
      end
    end
  endtask

  // Reference: rises of the sampled sigin that the meter acts on at edge ce = j+2.
  function automatic int count_rises(input int lo, input int hi);
    int c = 0;
    for (int j = lo - 2; j <= hi - 2; j++)
      if (j >= 1 && s_hist[j] && !s_hist[j-1]) c++;
    return c;
  endfunction

  function automatic int ref_period(input int e0, input int upto);
    int last = -1, prev = -1;
    for (int j = e0 - 2; j <= upto - 2; j++)
      if (j >= 1 && s_hist[j] && !s_hist[j-1]) begin
        prev = last;
        last = j + 2;
      end
    return (prev < 0) ? 0 : last - prev;
  endfunction

  initial begin
    int n, e0, last_v, nvalid, seg_left;
    bit saw;

    vecs[0] = '{hp: 5,  exp_freq: 10, exp_period: 10, exp_ovf: 0};
    vecs[1] = '{hp: 25, exp_freq: 2,  exp_period: 50, exp_ovf: 0};
    vecs[2] = '{hp: 0,  exp_freq: 0,  exp_period: 0,  exp_ovf: 0};
    vecs[3] = '{hp: 10, exp_freq: 5,  exp_period: 20, exp_ovf: 0};

    rst = 1'b1; en = 1'b0; en4 = 1'b0; sigin = 1'b0; sigin4 = 1'b0;
    for (int i = 0; i < HMAX; i++) s_hist[i] = 1'b0;

    // Reset state.
    reset_all();
    check("rst_freq", freq, 0);
    check("rst_period", period, 0);
    check("rst_valid", valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_freq4", freq4, 0);

    // Table-driven steady-state windows.
    for (int v = 0; v < 4; v++) begin
      reset_all();
      en = 1'b1;
      e0 = cyc + 1;
      last_v = e0;
      nvalid = 0;
      for (int t = 0; t < 3 * W + 5; t++) begin
        sigin = (vecs[v].hp == 0) ? 1'b0 : 1'(((t / vecs[v].hp) % 2));
        tick();
        if (valid) begin
          check($sformatf("v%0d_valid_spacing", v), cyc - last_v, W);
          check($sformatf("v%0d_freq", v), freq, vecs[v].exp_freq);
          check($sformatf("v%0d_period", v), period, vecs[v].exp_period);
          check($sformatf("v%0d_ovf", v), ovf, vecs[v].exp_ovf);
          last_v = cyc;
          nvalid++;
        end
      end
      check($sformatf("v%0d_valid_count", v), nvalid, 3);
    end

    // Abort mid-window, then re-enable.
    reset_all();
    en = 1'b1;
    for (int t = 0; t < W + 1; t++) begin
      sigin = 1'(((t / 5) % 2));
      tick();
    end
    n = 0;
    for (int t = 0; t < 50; t++) begin
      sigin = 1'(((t / 5) % 2));
      tick();
    end
    check("abort_busy_before", busy, 1);
    en = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    saw = 1'b0;
    for (int t = 0; t < 30; t++) begin
      tick();
      saw |= valid;
    end
    check("abort_no_valid", saw, 0);
    check("abort_freq_hold", freq, 10);
    check("abort_period_hold", period, 10);
    en = 1'b1;
    sigin = 1'b0;
    wait_valid(300, n);
    check("reenable_valid_edges", n, G + 2);
    check("reenable_freq", freq, 0);

    // Reset in the middle of a window with a good result already latched.
    reset_all();
    en = 1'b1;
    for (int t = 0; t < W + 40; t++) begin
      sigin = 1'(((t / 5) % 2));
      tick();
    end
    check("pre_rst_freq", freq, 10);
    rst = 1'b1;
    tick();
    check("midrst_freq", freq, 0);
    check("midrst_period", period, 0);
    check("midrst_valid", valid, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    sigin = 1'b0;
    wait_valid(300, n);
    check("post_rst_valid_edges", n, G + 2);

    // Narrow counter: saturation and overflow, then a quiet window.
    reset_all();
    en4 = 1'b1;
    e0 = cyc + 1;
    n = -1;
    for (int t = 0; t < 3 * W; t++) begin
      sigin4 = (cyc + 1 < e0 + G - 6) ? ~sigin4 : 1'b0;
      tick();
      if (valid4) begin
        n = cyc;
        break;
      end
    end
    check("ovf_first_valid_edge", n - e0, W);
    check("ovf_freq_sat", freq4, 15);
    check("ovf_flag", ovf4, 1);
    sigin4 = 1'b0;
    saw = 1'b0;
    for (int t = 0; t < W; t++) begin
      tick();
      saw |= valid4;
      if (valid4) break;
    end
    check("quiet_valid_seen", saw, 1);
    check("quiet_freq", freq4, 0);
    check("quiet_ovf", ovf4, 0);
    en4 = 1'b0;

    // Random sigin against the window/period reference.
    reset_all();
    repeat (4) tick();
    en = 1'b1;
    e0 = cyc + 1;
    seg_left = $urandom_range(1, 8);
    for (int t = 0; t < 4 * W + 3; t++) begin
      if (seg_left == 0) begin
        sigin = ~sigin;
        seg_left = $urandom_range(1, 8);
      end
      seg_left--;
      tick();
      check("rnd_valid", valid, ((cyc - e0) > 0 && ((cyc - e0) % W) == 0) ? 1 : 0);
      check("rnd_busy", busy, (((cyc - e0) % W) != G) ? 1 : 0);
      if (valid) begin
        check("rnd_freq", freq, count_rises(cyc - W + 1, cyc - 1));
        check("rnd_period", period, ref_period(e0, cyc));
        check("rnd_ovf", ovf, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL provide parameter GATE_CYCLES, default 50000000, gate window length in clkin cycles (1 s at 50 MHz).
REQ-002 SHALL provide parameter CNT_W, default 32, width of the edge counter and of freq.
REQ-003 SHALL provide port clkin  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port en  input  1  measurement enable, level-sensitive.
REQ-006 SHALL provide port sigin  input  1  measured signal, asynchronous to clkin (e.g. a divided clock).
REQ-007 SHALL provide port freq  output  CNT_W  rising edges counted in the last completed window.
REQ-008 SHALL provide port period  output  32  clkin cycles between the two most recent sigin rises.
REQ-009 SHALL provide port valid  output  1  one-cycle pulse when freq/ovf update.
REQ-010 SHALL provide port ovf  output  1  last completed window saturated the edge counter.
REQ-011 SHALL provide port busy  output  1  high while state is GATE.

Function
REQ-012 SHALL synchronise sigin through two flip-flops, then use a third flop for edge detect: rise = sync2 & ~sync3.
   - Latency from a sigin rise to rise = 3 clkin cycles.
REQ-013 SHALL implement states IDLE, GATE, LATCH.
REQ-014 IDLE: en=1 -> GATE next cycle, clearing gate_cnt and edge_cnt; en=0 -> stay.
REQ-015 GATE: gate_cnt increments every cycle; rise increments edge_cnt.
   - At gate_cnt == GATE_CYCLES-1 -> LATCH.
   - A rise on that final cycle is counted.
REQ-016 SHALL saturate edge_cnt at 2^CNT_W-1 and set an internal window-overflow flag, cleared at window start.
REQ-017 LATCH (exactly one cycle):
   - freq <= edge_cnt, ovf <= window flag, valid = 1.
   - Next state is GATE with counters cleared if en=1, else IDLE.
   - A rise during LATCH is not counted.
REQ-018 en=0 during GATE SHALL abort to IDLE next cycle.
   - No valid pulse; freq and ovf keep their previous values.
REQ-019 Period counter:
   - While en=1, run_cnt increments each cycle, saturating at 2^32-1.
   - On rise: period <= run_cnt if an earlier rise has been seen since enable; then run_cnt <= 1 and seen_edge <= 1.
REQ-020 en=0 SHALL clear seen_edge and run_cnt; period holds.
REQ-021 valid SHALL never be high on two consecutive cycles.
   - Windows repeat every GATE_CYCLES+1 cycles under continuous en.

Reset
REQ-022 rst SHALL force the following on the next clkin edge, taking priority over en and sigin:
   - state IDLE;
   - freq = 0, period = 0, valid = 0, ovf = 0, busy = 0;
   - all counters, seen_edge and the three sync/edge flops = 0.
REQ-023 rst asserted mid-window SHALL discard the partial count; no valid pulse.

Structure
REQ-024 Package freq_meter_pkg SHALL hold the state encoding constants (IDLE, GATE, LATCH) and the default GATE_CYCLES value.
REQ-025 SHALL instantiate one sub-module, edge_sync: 2-FF synchroniser plus rise detector, ports clkin, rst, din, rise.

Verification (GATE_CYCLES=100, CNT_W=32 unless stated)
REQ-026 sigin toggles every 5 cycles (period 10), en=1 -> freq=10, period=10, ovf=0, valid every 101 cycles.
REQ-027 sigin driven by a divider with half-period 25 cycles -> freq=2, period=50.
REQ-028 sigin held 0, en=1 -> valid every 101 cycles with freq=0; period stays 0.
REQ-029 en dropped at gate cycle 50 after one good window of freq=10 -> no valid, freq stays 10, busy=0; en re-raised -> next valid at 102 cycles.
REQ-030 rst asserted mid-GATE -> next cycle all outputs 0, state IDLE, and no valid pulse.
REQ-031 CNT_W=4, sigin toggling every cycle (50 rises per window) -> freq=15, ovf=1; next window with sigin=0 -> freq=0, ovf=0.
